// File: rtl/regbank_write_arbiter_if.sv
// Requester and register-bank write-port signals of regbank_write_arbiter.
// slave is the arbiter's view; master is the surrounding requesters plus bank.
interface regbank_write_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 2,
  parameter int unsigned DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic                      busy;
  logic                      we;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;
  logic                      done;
  logic                      err;

  modport master (
    output req, req_addr, req_data, done,
    input  ack, busy, we, wr_addr, wr_data, err
  );

  modport slave (
    input  req, req_addr, req_data, done,
    output ack, busy, we, wr_addr, wr_data, err
  );
endinterface

// File: rtl/regbank_write_arbiter.sv
// Round-robin arbiter sharing the register bank write port, sequencing we/done and acking.
// Optional done-wait timeout with sticky err: define REGBANK_TIMEOUT_EN.
module regbank_write_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned ADDR_W         = 2,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input logic                   clk,
  input logic                   reset,
  regbank_write_arbiter_if.slave bus
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("regbank_write_arbiter: NUM_REQ must be 2..4 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {StIdle, StWrite, StClear, StAck} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     grant_q, grant_d;
  logic [IdxW-1:0]     rr_q, rr_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [IdxW-1:0]     cand_idx;
  logic [IdxW-1:0]     pick_idx;
  logic                pick_vld;

`ifdef REGBANK_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            tmo;

  assign tmo = (32'(cnt_q) == TIMEOUT_CYCLES - 1);
`endif

  // First set request searching upward from the last winner, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand_idx = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand_idx = IdxW'((32'(rr_q) + off) % NUM_REQ);
      if (!pick_vld && bus.req[cand_idx]) begin
        pick_vld = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ack_d   = '0;
`ifdef REGBANK_TIMEOUT_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        we_d = 1'b0;
        // A lingering done means the bank is not ready for a fresh we.
        if (pick_vld && !bus.done) begin
          grant_d = pick_idx;
          rr_d    = pick_idx;
          addr_d  = bus.req_addr[pick_idx*ADDR_W +: ADDR_W];
          data_d  = bus.req_data[pick_idx*DATA_W +: DATA_W];
          we_d    = 1'b1;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (bus.done) begin
          we_d    = 1'b0;
          state_d = StClear;
        end
`ifdef REGBANK_TIMEOUT_EN
        else if (tmo) begin
          we_d    = 1'b0;
          err_d   = 1'b1;
          state_d = StIdle;
        end
`endif
      end
      StClear: begin
        we_d = 1'b0;
        if (!bus.done) begin
          ack_d[grant_q] = 1'b1;
          state_d        = StAck;
        end
`ifdef REGBANK_TIMEOUT_EN
        else if (tmo) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
`endif
      end
      StAck: state_d = StIdle;
      default: state_d = StIdle;
    endcase
`ifdef REGBANK_TIMEOUT_EN
    // Restart on every state entry; only WRITE and CLEAR are timed.
    if (state_d != state_q || state_q == StIdle || state_q == StAck) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      rr_q    <= IdxW'(NUM_REQ - 1);
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
    end
  end

`ifdef REGBANK_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.busy    = (state_q != StIdle);
  assign bus.we      = we_q;
  assign bus.wr_addr = addr_q;
  assign bus.wr_data = data_q;
  assign bus.ack     = ack_q;

endmodule
